dsp_post_adder_p: RTL and testbench



---
 rtl/dsp_post_adder_p.sv | 129 ++++++++++++
 tb/tb_dsp_post_adder_p.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_post_adder_p.sv
// Post-adder / accumulator and P output stage of a DSP48A1-style slice.
// Optional pattern detector is built when DSP_POST_ADDER_PATTERN_DETECT_EN is defined.
module dsp_post_adder_p #(
    parameter int PREG      = 1,
    parameter int OPMODEREG = 1,
    parameter int WIDTH     = 48,
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    parameter logic [WIDTH-1:0] PATTERN = '0,
    parameter logic [WIDTH-1:0] MASK    = '0,
`endif
    parameter int M_WIDTH   = 36
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_p,
    input  logic               ce_opmode,
    input  logic [7:0]         opmode,
    input  logic [M_WIDTH-1:0] m,
    input  logic [WIDTH-1:0]   dab,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   pcin,
    input  logic               carry_in,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   p,
    output logic [WIDTH-1:0]   pcout,
    output logic               carry_out,
    output logic               carry_out_f,
    output logic               out_valid,
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    output logic               pattern_detect,
    output logic               pattern_bdetect,
`endif
    output logic               opmode_err
);

    logic [7:0]       opmode_q, opmode_d, opmode_eff;
    logic [WIDTH-1:0] p_q, p_d, p_next, p_fb, x_mux, z_mux;
    logic             carry_q, carry_d, carry_next;
    logic             valid_q, valid_d;
    logic [WIDTH:0]   cin_ext, r;
    logic             unused_opmode_bits;

    always_comb begin
        opmode_d   = ce_opmode ? opmode : opmode_q;
        opmode_eff = (OPMODEREG != 0) ? opmode_q : opmode;
        // Without a P register there is nothing to feed back, so P selects read as 0.
        p_fb       = (PREG != 0) ? p_q : '0;

        x_mux = '0;
        case (opmode_eff[1:0])
            2'd0: x_mux = '0;
            2'd1: x_mux = {{(WIDTH-M_WIDTH){m[M_WIDTH-1]}}, m};
            2'd2: x_mux = p_fb;
            default: x_mux = dab;
        endcase

        z_mux = '0;
        case (opmode_eff[3:2])
            2'd0: z_mux = '0;
            2'd1: z_mux = pcin;
            2'd2: z_mux = p_fb;
            default: z_mux = c;
        endcase

        cin_ext = {{WIDTH{1'b0}}, carry_in & opmode_eff[5]};
        if (opmode_eff[7])
            r = {1'b0, z_mux} - ({1'b0, x_mux} + cin_ext);
        else
            r = {1'b0, z_mux} + {1'b0, x_mux} + cin_ext;

        p_next     = r[WIDTH-1:0];
        carry_next = r[WIDTH];

        p_d     = ce_p ? p_next     : p_q;
        carry_d = ce_p ? carry_next : carry_q;
        valid_d = ce_p ? in_valid   : valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opmode_q <= '0;
            p_q      <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            opmode_q <= opmode_d;
            p_q      <= p_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
        end
    end

    assign p           = (PREG != 0) ? p_q     : p_next;
    assign carry_out   = (PREG != 0) ? carry_q : carry_next;
    assign out_valid   = (PREG != 0) ? valid_q : in_valid;
    assign pcout       = p;
    assign carry_out_f = carry_out;
    assign opmode_err  = (PREG == 0) && ((opmode_eff[1:0] == 2'd2) || (opmode_eff[3:2] == 2'd2));

    assign unused_opmode_bits = opmode_eff[6] ^ opmode_eff[4];

`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    logic pd_q, pd_d, pd_next;
    logic pbd_q, pbd_d, pbd_next;

    always_comb begin
        pd_next  = ((p_next ^ PATTERN) & ~MASK) == '0;
        pbd_next = ((p_next ^ ~PATTERN) & ~MASK) == '0;
        pd_d     = ce_p ? pd_next  : pd_q;
        pbd_d    = ce_p ? pbd_next : pbd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pd_q  <= 1'b0;
            pbd_q <= 1'b0;
        end else begin
            pd_q  <= pd_d;
            pbd_q <= pbd_d;
        end
    end

    assign pattern_detect  = (PREG != 0) ? pd_q  : pd_next;
    assign pattern_bdetect = (PREG != 0) ? pbd_q : pbd_next;
`else
    // Detector absent: no extra ports or state in this build.
`endif

endmodule

// File: tb/tb_dsp_post_adder_p.sv
// Bench for dsp_post_adder_p: registered instance checked against a reference
// model through an expected queue, plus a combinational (PREG=0) instance.
module tb_dsp_post_adder_p;
  localparam int W  = 48;
  localparam int MW = 36;
  localparam int EW = W + 4;

  logic          clk = 1'b0;
  logic          rst, ce_p, ce_opmode, carry_in, in_valid;
  logic [7:0]    opmode, opmode2;
  logic [MW-1:0] m;
  logic [W-1:0]  dab, c, pcin;

  logic [W-1:0]  p, pcout, p2, pcout2;
  logic          carry_out, carry_out_f, out_valid, opmode_err;
  logic          carry_out2, carry_out_f2, out_valid2, opmode_err2;
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
  logic          pd, pbd, pd2, pbd2;
`endif

  // Reference model state for the registered instance
  logic [7:0]    m_op;
  logic [W-1:0]  m_p;
  logic          m_c, m_v, m_pd, m_bd;

  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  dsp_post_adder_p #(.PREG(1), .OPMODEREG(1), .WIDTH(W), .M_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .ce_p(ce_p), .ce_opmode(ce_opmode), .opmode(opmode),
    .m(m), .dab(dab), .c(c), .pcin(pcin), .carry_in(carry_in), .in_valid(in_valid),
    .p(p), .pcout(pcout), .carry_out(carry_out), .carry_out_f(carry_out_f),
    .out_valid(out_valid),
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    .pattern_detect(pd), .pattern_bdetect(pbd),
`endif
    .opmode_err(opmode_err)
  );

  dsp_post_adder_p #(.PREG(0), .OPMODEREG(0), .WIDTH(W),
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    .PATTERN(48'd77), .MASK(48'd0),
`endif
    .M_WIDTH(MW)) dut_comb (
    .clk(clk), .rst(rst), .ce_p(ce_p), .ce_opmode(ce_opmode), .opmode(opmode2),
    .m(m), .dab(dab), .c(c), .pcin(pcin), .carry_in(carry_in), .in_valid(in_valid),
    .p(p2), .pcout(pcout2), .carry_out(carry_out2), .carry_out_f(carry_out_f2),
    .out_valid(out_valid2),
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    .pattern_detect(pd2), .pattern_bdetect(pbd2),
`endif
    .opmode_err(opmode_err2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] calc(input logic [7:0] op, input logic [W-1:0] fb,
                                      input logic [MW-1:0] mi, input logic [W-1:0] di,
                                      input logic [W-1:0] ci, input logic [W-1:0] pi,
                                      input logic cy);
    logic [W-1:0] xv, zv;
    logic [W:0]   cv;
    case (op[1:0])
      2'd0: xv = '0;
      2'd1: xv = {{(W-MW){mi[MW-1]}}, mi};
      2'd2: xv = fb;
      default: xv = di;
    endcase
    case (op[3:2])
      2'd0: zv = '0;
      2'd1: zv = pi;
      2'd2: zv = fb;
      default: zv = ci;
    endcase
    cv = {{W{1'b0}}, cy & op[5]};
    if (op[7]) return {1'b0, zv} - ({1'b0, xv} + cv);
    return {1'b0, zv} + {1'b0, xv} + cv;
  endfunction

  // One clock of the registered instance: model the edge, queue it, compare after the edge.
  task automatic step();
    logic [W:0]    r;
    logic [EW-1:0] e;
    r = calc(m_op, m_p, m, dab, c, pcin, carry_in);
    if (rst) begin
      m_op = '0; m_p = '0; m_c = 1'b0; m_v = 1'b0; m_pd = 1'b0; m_bd = 1'b0;
    end else begin
      if (ce_p) begin
        m_p = r[W-1:0]; m_c = r[W]; m_v = in_valid;
        m_pd = (r[W-1:0] == '0); m_bd = (r[W-1:0] == '1);
      end
      if (ce_opmode) m_op = opmode;
    end
    exp_q.push_back({m_bd, m_pd, m_v, m_c, m_p});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("p", 64'(p), 64'(e[W-1:0]));
    check("pcout", 64'(pcout), 64'(e[W-1:0]));
    check("carry_out", 64'(carry_out), 64'(e[W]));
    check("carry_out_f", 64'(carry_out_f), 64'(e[W]));
    check("out_valid", 64'(out_valid), 64'(e[W+1]));
    check("opmode_err", 64'(opmode_err), 64'd0);
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    check("pattern_detect", 64'(pd), 64'(e[W+2]));
    check("pattern_bdetect", 64'(pbd), 64'(e[W+3]));
`endif
  endtask

  initial begin
    rst = 1'b1; ce_p = 1'b1; ce_opmode = 1'b1; carry_in = 1'b0; in_valid = 1'b1;
    opmode = 8'h01; opmode2 = 8'h00; m = 36'd30; dab = '0; c = '0; pcin = '0;
    m_op = '0; m_p = '0; m_c = 1'b0; m_v = 1'b0; m_pd = 1'b0; m_bd = 1'b0;

    // Reset held with live operands and ce_p=1
    for (int i = 0; i < 10; i++) step();
    check("rst_p", 64'(p), 64'd0);
    rst = 1'b0;
    step();
    step();
    check("rel_p30", 64'(p), 64'd30);

    // Accumulate 5 per cycle from a fresh reset, then hold
    rst = 1'b1; opmode = 8'h09; m = 36'd5;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("acc", 64'(p), 64'(5 * (i + 1)));
    end
    ce_p = 1'b0; in_valid = 1'b0;
    step();
    step();
    check("hold_p20", 64'(p), 64'd20);
    check("hold_valid", 64'(out_valid), 64'd1);
    ce_p = 1'b1;

    // Wrap: all-ones C plus DAB=1
    opmode = 8'h0F; c = {W{1'b1}}; dab = 48'd1; in_valid = 1'b1;
    step();
    step();
    check("wrap_p", 64'(p), 64'd0);
    check("wrap_carry", 64'(carry_out), 64'd1);
    check("wrap_carry_f", 64'(carry_out_f), 64'd1);

    // Subtract with carry, then a borrow
    opmode = 8'hAD; c = 48'd100; m = 36'd40; carry_in = 1'b1;
    step();
    step();
    check("sub_p59", 64'(p), 64'd59);
    check("sub_carry0", 64'(carry_out), 64'd0);
    c = 48'd10; carry_in = 1'b0;
    step();
    check("sub_neg", 64'(p), 64'(48'hFFFF_FFFF_FFE2));
    check("sub_borrow", 64'(carry_out), 64'd1);

    // Cascade, with opmode held off by ce_opmode for one cycle
    opmode = 8'h05; pcin = 48'd1000; m = {MW{1'b1}}; ce_opmode = 1'b0;
    step();
    ce_opmode = 1'b1;
    step();
    step();
    check("casc_p999", 64'(p), 64'd999);
    check("casc_pcout999", 64'(pcout), 64'd999);

    // Randomised traffic through the model
    for (int i = 0; i < 60; i++) begin
      rst       = ($urandom_range(0, 15) == 0);
      ce_p      = ($urandom_range(0, 3) != 0);
      ce_opmode = ($urandom_range(0, 3) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      carry_in  = 1'($urandom_range(0, 1));
      opmode    = 8'($urandom_range(0, 255));
      m         = {4'($urandom_range(0, 15)), 32'($urandom)};
      dab       = {16'($urandom_range(0, 65535)), 32'($urandom)};
      c         = {16'($urandom_range(0, 65535)), 32'($urandom)};
      pcin      = {16'($urandom_range(0, 65535)), 32'($urandom)};
      if (i > 50) c = {W{1'b1}};
      step();
    end

    // Combinational instance: P selects read as 0 and flag opmode_err
    rst = 1'b1; ce_p = 1'b1; carry_in = 1'b0; in_valid = 1'b1;
    opmode2 = 8'h0E; c = 48'd77; dab = 48'd9; m = 36'd3;
    #1;
    check("comb_x2_p", 64'(p2), 64'd77);
    check("comb_x2_err", 64'(opmode_err2), 64'd1);
    check("comb_valid", 64'(out_valid2), 64'd1);
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    check("comb_pd", 64'(pd2), 64'd1);
`endif
    opmode2 = 8'h01; m = {MW{1'b1}} - 36'd2; in_valid = 1'b0;
    #1;
    check("comb_neg3", 64'(p2), 64'(48'hFFFF_FFFF_FFFD));
    check("comb_neg3_err", 64'(opmode_err2), 64'd0);
    check("comb_invalid", 64'(out_valid2), 64'd0);
`ifdef DSP_POST_ADDER_PATTERN_DETECT_EN
    check("comb_pd0", 64'(pd2), 64'd0);
`endif
    opmode2 = 8'h0B; dab = 48'd5;
    #1;
    check("comb_z2_p", 64'(p2), 64'd5);
    check("comb_z2_err", 64'(opmode_err2), 64'd1);
    opmode2 = 8'h0F; dab = 48'd1; c = {W{1'b1}};
    #1;
    check("comb_wrap_p", 64'(p2), 64'd0);
    check("comb_wrap_carry", 64'(carry_out2), 64'd1);
    check("comb_wrap_carry_f", 64'(carry_out_f2), 64'd1);
    check("comb_pcout", 64'(pcout2), 64'd0);
    @(posedge clk);
    #1;
    check("comb_same_after_edge", 64'(p2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
